alu_divider: RTL and testbench

Iterative unsigned restoring divider that supplies the division operation the combinational ALU does not provide: it accepts a dividend and divisor through a start/done handshake and returns quotient and remainder after a fixed number of cycles. It sits beside the ALU on the same 16-bit operand buses. The datapath controller issues `start`, waits for `done`, then latches results into the register file. One quotient bit is resolved per clock.

---
 rtl/alu_pkg.sv | 8 +
 rtl/div_step.sv | 19 +
 rtl/alu_divider.sv | 101 ++++++++++
 tb/tb_alu_divider.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU constants and divider FSM state encodings.
package alu_pkg;
    localparam int ALU_WIDTH = 16;
    localparam int ALU_CNT_W = $clog2(ALU_WIDTH);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring-division iteration.
module div_step
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic             bit_i,
    input  logic [WIDTH-1:0] dvs_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             q_o
);
    // Shifted remainder is WIDTH+1 bits so the trial subtract cannot overflow.
    logic [WIDTH:0] shifted, diff;
    assign shifted = {rem_i, bit_i};
    assign diff    = shifted - {1'b0, dvs_i};
    assign q_o     = shifted >= {1'b0, dvs_i};
    assign rem_o   = q_o ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
endmodule

// File: rtl/alu_divider.sv
// alu_divider: iterative unsigned restoring divider with start/done handshake,
// resolving one quotient bit per clock.
module alu_divider
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    localparam int CW = $clog2(WIDTH);

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d, dvd_q, dvd_d, dvs_q, dvs_d;
    logic [WIDTH-1:0] quo_q, quo_d, res_q, res_d;
    logic             dbz_q, dbz_d;
    logic [WIDTH-1:0] step_rem;
    logic             step_q;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i (rem_q),
        .bit_i (dvd_q[WIDTH-1]),
        .dvs_i (dvs_q),
        .rem_o (step_rem),
        .q_o   (step_q)
    );

    // Quotient bits shift into the dividend register as its bits shift out.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        quo_d   = quo_q;
        res_d   = res_q;
        dbz_d   = dbz_q;
        if (state_q == S_RUN) begin
            rem_d = step_rem;
            dvd_d = {dvd_q[WIDTH-2:0], step_q};
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == '0) begin
                state_d = S_DONE;
                quo_d   = dvd_d;
                res_d   = step_rem;
            end
        end else if (start) begin
            dbz_d = divisor == '0;
            if (divisor == '0) begin
                state_d = S_DONE;
                quo_d   = '1;
                res_d   = dividend;
            end else begin
                state_d = S_RUN;
                dvd_d   = dividend;
                dvs_d   = divisor;
                rem_d   = '0;
                cnt_d   = CW'(WIDTH - 1);
            end
        end else begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            quo_q   <= '0;
            res_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            quo_q   <= quo_d;
            res_q   <= res_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy        = state_q == S_RUN;
    assign done        = state_q == S_DONE;
    assign quotient    = quo_q;
    assign remainder   = res_q;
    assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_alu_divider.sv
// tb_alu_divider: directed and back-to-back random checks of alu_divider.
module tb_alu_divider;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] dividend = '0;
    logic [15:0] divisor = '0;
    logic        busy, done, div_by_zero;
    logic [15:0] quotient, remainder;
    int checks = 0;
    int errors = 0;

    alu_divider dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    // Issues one start and returns cycles until done (40 = timeout) and busy cycles seen.
    task automatic run_div(input logic [15:0] a, input logic [15:0] b, output int lat, output int bcnt);
        @(negedge clk);
        start = 1'b1; dividend = a; divisor = b;
        @(negedge clk);
        start = 1'b0; lat = 1; bcnt = 0;
        while (!done && lat < 40) begin
            bcnt += int'(busy);
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (quotient !== 16'h0) begin errors++; $display("FAIL reset_quot got %h want 0000", quotient); end
        checks++; if (remainder !== 16'h0) begin errors++; $display("FAIL reset_rem got %h want 0000", remainder); end
        checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dbz got %b want 0", div_by_zero); end
        rst_n = 1'b1;
    endtask

    task automatic test_basic;
        int lat, bcnt;
        run_div(16'd100, 16'd7, lat, bcnt);
        checks++; if (lat !== 17) begin errors++; $display("FAIL basic_latency got %0d want 17", lat); end
        checks++; if (bcnt !== 16) begin errors++; $display("FAIL basic_busy_cycles got %0d want 16", bcnt); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_in_done got %b want 0", busy); end
        checks++; if (quotient !== 16'd14) begin errors++; $display("FAIL basic_quot got %0d want 14", quotient); end
        checks++; if (remainder !== 16'd2) begin errors++; $display("FAIL basic_rem got %0d want 2", remainder); end
        checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL basic_dbz got %b want 0", div_by_zero); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got %b want 0", done); end
    endtask

    task automatic test_edges;
        int lat, bcnt;
        run_div(16'hFFFF, 16'd1, lat, bcnt);
        checks++; if (quotient !== 16'hFFFF) begin errors++; $display("FAIL max_div1_quot got %h want ffff", quotient); end
        checks++; if (remainder !== 16'h0) begin errors++; $display("FAIL max_div1_rem got %h want 0000", remainder); end
        run_div(16'd3, 16'd10, lat, bcnt);
        checks++; if (quotient !== 16'd0) begin errors++; $display("FAIL small_quot got %0d want 0", quotient); end
        checks++; if (remainder !== 16'd3) begin errors++; $display("FAIL small_rem got %0d want 3", remainder); end
    endtask

    task automatic test_div_zero;
        int lat, bcnt;
        run_div(16'd5, 16'd0, lat, bcnt);
        checks++; if (lat !== 1) begin errors++; $display("FAIL dz_latency got %0d want 1", lat); end
        checks++; if (bcnt !== 0) begin errors++; $display("FAIL dz_busy_cycles got %0d want 0", bcnt); end
        checks++; if (quotient !== 16'hFFFF) begin errors++; $display("FAIL dz_quot got %h want ffff", quotient); end
        checks++; if (remainder !== 16'd5) begin errors++; $display("FAIL dz_rem got %0d want 5", remainder); end
        checks++; if (div_by_zero !== 1'b1) begin errors++; $display("FAIL dz_flag got %b want 1", div_by_zero); end
        repeat (3) @(negedge clk);
        checks++; if (div_by_zero !== 1'b1 || quotient !== 16'hFFFF || remainder !== 16'd5)
            begin errors++; $display("FAIL dz_hold got dbz=%b q=%h r=%0d want dbz=1 q=ffff r=5", div_by_zero, quotient, remainder); end
        run_div(16'd6, 16'd3, lat, bcnt);
        checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL dz_clear got %b want 0", div_by_zero); end
        checks++; if (quotient !== 16'd2 || remainder !== 16'd0)
            begin errors++; $display("FAIL dz_next got q=%0d r=%0d want q=2 r=0", quotient, remainder); end
    endtask

    task automatic test_ignore_start;
        int lat;
        @(negedge clk);
        start = 1'b1; dividend = 16'd100; divisor = 16'd7;
        @(negedge clk);
        start = 1'b0; lat = 1;
        repeat (4) begin @(negedge clk); lat++; end
        start = 1'b1; dividend = 16'd9; divisor = 16'd2;
        @(negedge clk);
        start = 1'b0; lat++;
        while (!done && lat < 40) begin @(negedge clk); lat++; end
        checks++; if (lat !== 17) begin errors++; $display("FAIL ign_latency got %0d want 17", lat); end
        checks++; if (quotient !== 16'd14 || remainder !== 16'd2)
            begin errors++; $display("FAIL ign_result got q=%0d r=%0d want q=14 r=2", quotient, remainder); end
        @(negedge clk);
        checks++; if (busy !== 1'b0 || done !== 1'b0)
            begin errors++; $display("FAIL ign_restart got busy=%b done=%b want 0 0", busy, done); end
    endtask

    task automatic test_reset_mid;
        int lat, bcnt, seen;
        @(negedge clk);
        start = 1'b1; dividend = 16'd1000; divisor = 16'd33;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++; if (busy !== 1'b0 || done !== 1'b0 || quotient !== 16'h0 || remainder !== 16'h0 || div_by_zero !== 1'b0)
            begin errors++; $display("FAIL mid_reset got busy=%b done=%b q=%h r=%h dbz=%b want all 0", busy, done, quotient, remainder, div_by_zero); end
        seen = 0;
        repeat (20) begin @(negedge clk); seen += int'(done) + int'(busy); end
        checks++; if (seen !== 0) begin errors++; $display("FAIL mid_no_done got %0d active cycles want 0", seen); end
        run_div(16'd1000, 16'd33, lat, bcnt);
        checks++; if (lat !== 17) begin errors++; $display("FAIL mid_latency got %0d want 17", lat); end
        checks++; if (quotient !== 16'd30 || remainder !== 16'd10)
            begin errors++; $display("FAIL mid_result got q=%0d r=%0d want q=30 r=10", quotient, remainder); end
    endtask

    task automatic test_back_to_back;
        logic [15:0] a, b, ea, eb, eq, er;
        int lat, bcnt;
        ea = 16'd12345; eb = 16'd67;
        @(negedge clk);
        start = 1'b1; dividend = ea; divisor = eb;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            start = 1'b0; lat = 1; bcnt = 0;
            while (!done && lat < 40) begin bcnt += int'(busy); @(negedge clk); lat++; end
            eq = (eb == 0) ? 16'hFFFF : ea / eb;
            er = (eb == 0) ? ea : ea % eb;
            checks++; if (lat !== ((eb == 0) ? 1 : 17) || bcnt !== ((eb == 0) ? 0 : 16))
                begin errors++; $display("FAIL b2b_timing[%0d] got lat=%0d busy=%0d for %0d/%0d", i, lat, bcnt, ea, eb); end
            checks++; if (quotient !== eq || remainder !== er || div_by_zero !== (eb == 0))
                begin errors++; $display("FAIL b2b_result[%0d] %0d/%0d got q=%0d r=%0d dbz=%b want q=%0d r=%0d dbz=%b", i, ea, eb, quotient, remainder, div_by_zero, eq, er, eb == 0); end
            a = 16'($urandom);
            case (i % 4)
                0: b = 16'($urandom);
                1: b = 16'($urandom_range(1, 255));
                2: begin b = 16'($urandom_range(1, 65535)); a = 16'($urandom_range(0, 40)); end
                default: b = (i % 97 == 3) ? 16'd0 : 16'($urandom_range(1, 15));
            endcase
            start = 1'b1; dividend = a; divisor = b;
            ea = a; eb = b;
        end
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
    endtask

    initial begin
        test_reset;
        test_basic;
        test_edges;
        test_div_zero;
        test_ignore_start;
        test_reset_mid;
        test_back_to_back;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
